// File: rtl/axi_sram_slave_p_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_sram_slave_p_if
// Description : AXI4 five-channel bundle (AR/R/AW/W/B) for the SRAM slave,
//               with master and slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_sram_slave_p_if #(
    parameter int DATA_W = 32,
    parameter int IDS_W  = 8,
    parameter int LEN_W  = 4
);
    // Read address channel
    logic [IDS_W-1:0]    ARID_S;
    logic [31:0]         ARADDR_S;
    logic [LEN_W-1:0]    ARLEN_S;
    logic [2:0]          ARSIZE_S;
    logic [1:0]          ARBURST_S;
    logic                ARVALID_S;
    logic                ARREADY_S;
    // Read data channel
    logic [IDS_W-1:0]    RID_S;
    logic [DATA_W-1:0]   RDATA_S;
    logic [1:0]          RRESP_S;
    logic                RLAST_S;
    logic                RVALID_S;
    logic                RREADY_S;
    // Write address channel
    logic [IDS_W-1:0]    AWID_S;
    logic [31:0]         AWADDR_S;
    logic [LEN_W-1:0]    AWLEN_S;
    logic [2:0]          AWSIZE_S;
    logic [1:0]          AWBURST_S;
    logic                AWVALID_S;
    logic                AWREADY_S;
    // Write data channel
    logic [DATA_W-1:0]   WDATA_S;
    logic [DATA_W/8-1:0] WSTRB_S;
    logic                WLAST_S;
    logic                WVALID_S;
    logic                WREADY_S;
    // Write response channel
    logic [IDS_W-1:0]    BID_S;
    logic [1:0]          BRESP_S;
    logic                BVALID_S;
    logic                BREADY_S;

    modport slave (
        input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
        output ARREADY_S,
        output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
        input  RREADY_S,
        input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
        output AWREADY_S,
        input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
        output WREADY_S,
        output BID_S, BRESP_S, BVALID_S,
        input  BREADY_S
    );

    modport master (
        output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
        input  ARREADY_S,
        input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
        output RREADY_S,
        output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
        input  AWREADY_S,
        output WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
        input  WREADY_S,
        input  BID_S, BRESP_S, BVALID_S,
        output BREADY_S
    );
endinterface
`default_nettype wire

// File: rtl/axi_sram_slave_p.sv
`default_nettype none
// ============================================================================
// Module      : axi_sram_slave_p
// Description : AXI4 slave in front of a behavioural single-port SRAM.
//               One burst at a time, round-robin AR/AW arbitration,
//               FIXED/INCR/WRAP bursts, SLVERR on illegal bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_sram_slave_p #(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 14,
    parameter int IDS_W  = 8,
    parameter int LEN_W  = 4
) (
    input  wire logic          ACLK,
    input  wire logic          ARESET,
    axi_sram_slave_p_if.slave  axi_io
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int DEPTH  = 2 ** MEM_AW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RD    = 2'd1;
    localparam logic [1:0] S_WR    = 2'd2;
    localparam logic [1:0] S_WRESP = 2'd3;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Next word address for the burst type; WRAP relies on LEN being 2^n-1
    // so LEN itself is the in-window offset mask.
    function automatic logic [MEM_AW-1:0] f_next_addr(
        input logic [MEM_AW-1:0] a,
        input logic [LEN_W-1:0]  len,
        input logic [1:0]        burst
    );
        logic [MEM_AW-1:0] mask;
        logic [MEM_AW-1:0] inc;
        mask = MEM_AW'(len);
        inc  = a + MEM_AW'(1);
        case (burst)
            BURST_FIXED: f_next_addr = a;
            BURST_WRAP:  f_next_addr = (a & ~mask) | (inc & mask);
            default:     f_next_addr = inc;
        endcase
    endfunction

    // Bursts this slave refuses to serve: wrong beat size, reserved burst
    // type, or a WRAP length that is not 2/4/8/16 beats.
    function automatic logic f_err(
        input logic [2:0]       size,
        input logic [1:0]       burst,
        input logic [LEN_W-1:0] len
    );
        logic [31:0] beats;
        beats = 32'(len) + 32'd1;
        f_err = (size != 3'(OFF)) || (burst == 2'b11) ||
                ((burst == BURST_WRAP) && (beats != 32'd2) && (beats != 32'd4) &&
                 (beats != 32'd8) && (beats != 32'd16));
    endfunction

    logic [1:0]        state_q, state_d;
    logic              prio_wr_q;
    logic [IDS_W-1:0]  id_q;
    logic [LEN_W-1:0]  len_q;
    logic [1:0]        burst_q;
    logic [MEM_AW-1:0] addr_q;
    logic              err_q;
    logic [LEN_W-1:0]  beat_q;
    logic              rlast_q;
    logic              wdone_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic w_arready, w_awready, w_rvalid, w_wready, w_bvalid;
    logic w_both;
    logic w_ar_hs, w_aw_hs, w_r_hs, w_w_hs, w_b_hs;
    logic w_ar_err, w_aw_err;
    logic [MEM_AW-1:0] w_ar_waddr, w_aw_waddr, w_rd_addr;
    logic w_rd_err, w_mem_re, w_mem_we;
    logic w_beat_is_last;
    logic w_unused;

    assign w_ar_waddr = axi_io.ARADDR_S[MEM_AW+OFF-1:OFF];
    assign w_aw_waddr = axi_io.AWADDR_S[MEM_AW+OFF-1:OFF];
    assign w_ar_err   = f_err(axi_io.ARSIZE_S, axi_io.ARBURST_S, axi_io.ARLEN_S);
    assign w_aw_err   = f_err(axi_io.AWSIZE_S, axi_io.AWBURST_S, axi_io.AWLEN_S);
    assign w_both     = axi_io.ARVALID_S & axi_io.AWVALID_S;
    assign w_unused   = ^{axi_io.ARADDR_S[31:MEM_AW+OFF], axi_io.ARADDR_S[OFF-1:0],
                          axi_io.AWADDR_S[31:MEM_AW+OFF], axi_io.AWADDR_S[OFF-1:0]};

    // State register
    always_ff @(posedge ACLK) begin
        if (ARESET) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_aw_hs) state_d = S_WR;
                     else if (w_ar_hs) state_d = S_RD;
            S_RD:    if (w_r_hs && rlast_q) state_d = S_IDLE;
            S_WR:    if (w_w_hs && axi_io.WLAST_S) state_d = S_WRESP;
            S_WRESP: if (w_b_hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs per state; in IDLE the loser of a tie is held off
    always_comb begin
        w_arready = 1'b0;
        w_awready = 1'b0;
        w_rvalid  = 1'b0;
        w_wready  = 1'b0;
        w_bvalid  = 1'b0;
        case (state_q)
            S_IDLE: if (!ARESET) begin
                w_arready = ~(w_both & prio_wr_q);
                w_awready = ~(w_both & ~prio_wr_q);
            end
            S_RD:    w_rvalid = 1'b1;
            S_WR:    w_wready = 1'b1;
            S_WRESP: w_bvalid = 1'b1;
            default: ;
        endcase
    end

    assign w_ar_hs = w_arready & axi_io.ARVALID_S;
    assign w_aw_hs = w_awready & axi_io.AWVALID_S;
    assign w_r_hs  = w_rvalid  & axi_io.RREADY_S;
    assign w_w_hs  = w_wready  & axi_io.WVALID_S;
    assign w_b_hs  = w_bvalid  & axi_io.BREADY_S;

    assign w_beat_is_last = (beat_q == len_q);

    // Reads happen on the AR handshake and on every non-last R handshake,
    // so the next beat is ready the cycle after the current one is taken.
    assign w_mem_re  = w_ar_hs | (w_r_hs & ~rlast_q);
    assign w_rd_addr = (state_q == S_IDLE) ? w_ar_waddr : addr_q;
    assign w_rd_err  = (state_q == S_IDLE) ? w_ar_err : err_q;
    assign w_mem_we  = w_w_hs & ~err_q & ~wdone_q & ~ARESET;

    // Burst context: latched at address handshake, advanced per beat
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            prio_wr_q <= 1'b1;
            id_q      <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            beat_q    <= '0;
            rlast_q   <= 1'b0;
            wdone_q   <= 1'b0;
        end else if (w_aw_hs) begin
            prio_wr_q <= 1'b0;
            id_q      <= axi_io.AWID_S;
            len_q     <= axi_io.AWLEN_S;
            burst_q   <= axi_io.AWBURST_S;
            addr_q    <= w_aw_waddr;
            err_q     <= w_aw_err;
            beat_q    <= '0;
            rlast_q   <= 1'b0;
            wdone_q   <= 1'b0;
        end else if (w_ar_hs) begin
            prio_wr_q <= 1'b1;
            id_q      <= axi_io.ARID_S;
            len_q     <= axi_io.ARLEN_S;
            burst_q   <= axi_io.ARBURST_S;
            addr_q    <= f_next_addr(w_ar_waddr, axi_io.ARLEN_S, axi_io.ARBURST_S);
            err_q     <= w_ar_err;
            beat_q    <= '0;
            rlast_q   <= (axi_io.ARLEN_S == '0);
        end else if (w_r_hs) begin
            if (rlast_q) begin
                rlast_q <= 1'b0;
            end else begin
                addr_q  <= f_next_addr(addr_q, len_q, burst_q);
                beat_q  <= beat_q + LEN_W'(1);
                rlast_q <= ((beat_q + LEN_W'(1)) == len_q);
            end
        end else if (w_w_hs && !wdone_q) begin
            // WLAST must coincide with beat LEN; any mismatch poisons BRESP
            addr_q <= f_next_addr(addr_q, len_q, burst_q);
            beat_q <= beat_q + LEN_W'(1);
            if (w_beat_is_last) wdone_q <= 1'b1;
            if (axi_io.WLAST_S != w_beat_is_last) err_q <= 1'b1;
        end
    end

    // Read data output register: doubles as the SRAM's synchronous read port
    always_ff @(posedge ACLK) begin
        if (ARESET)        rdata_q <= '0;
        else if (w_mem_re) rdata_q <= w_rd_err ? '0 : mem_q[w_rd_addr];
    end

    // Byte-enabled SRAM write; contents survive reset
    always_ff @(posedge ACLK) begin
        if (w_mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi_io.WSTRB_S[b]) mem_q[addr_q][b*8 +: 8] <= axi_io.WDATA_S[b*8 +: 8];
            end
        end
    end

    assign axi_io.ARREADY_S = w_arready;
    assign axi_io.AWREADY_S = w_awready;
    assign axi_io.RVALID_S  = w_rvalid;
    assign axi_io.WREADY_S  = w_wready;
    assign axi_io.BVALID_S  = w_bvalid;
    assign axi_io.RDATA_S   = rdata_q;
    assign axi_io.RID_S     = id_q;
    assign axi_io.BID_S     = id_q;
    assign axi_io.RRESP_S   = {err_q, 1'b0};
    assign axi_io.BRESP_S   = {err_q, 1'b0};
    assign axi_io.RLAST_S   = rlast_q;
endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_sram_slave_p
// Description : Self-checking bench for axi_sram_slave_p: table of read
//               bursts plus hand-written write/arbitration/reset sequences,
//               R beats compared against a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_sram_slave_p;
    localparam int DW = 32;
    localparam int AW = 14;
    localparam int IW = 8;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_sram_slave_p_if #(.DATA_W(DW), .IDS_W(IW), .LEN_W(LW)) bus ();

    axi_sram_slave_p #(.DATA_W(DW), .MEM_AW(AW), .IDS_W(IW), .LEN_W(LW)) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .axi_io (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [7:0]  id;
    } rbeat_t;

    typedef struct {
        logic [7:0]       id;
        logic [31:0]      addr;
        logic [3:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [1:0]       resp;
        logic [3:0][31:0] ea;
    } rvec_t;

    rbeat_t      exp_q[$];
    logic [31:0] model [int];
    int          errors   = 0;
    int          checks   = 0;
    int          beat_cnt = 0;
    logic        held     = 1'b0;
    rbeat_t      hold_b;
    rbeat_t      mon_e;
    rvec_t       tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // R monitor: beats are taken at the edge following a negedge with VALID&READY
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("r_hold_valid", 32'(bus.RVALID_S), 32'd1);
                chk("r_hold_data",  bus.RDATA_S, hold_b.data);
                chk("r_hold_last",  32'(bus.RLAST_S), 32'(hold_b.last));
                chk("r_hold_id",    32'(bus.RID_S), 32'(hold_b.id));
            end
            if (bus.RVALID_S && bus.RREADY_S) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_extra_beat: got data 0x%0h, expected no beat", bus.RDATA_S);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("r_data", bus.RDATA_S, mon_e.data);
                    chk("r_resp", 32'(bus.RRESP_S), 32'(mon_e.resp));
                    chk("r_last", 32'(bus.RLAST_S), 32'(mon_e.last));
                    chk("r_id",   32'(bus.RID_S), 32'(mon_e.id));
                end
                beat_cnt++;
            end
            held   = bus.RVALID_S && !bus.RREADY_S;
            hold_b = '{data: bus.RDATA_S, resp: bus.RRESP_S, last: bus.RLAST_S, id: bus.RID_S};
        end
    end

    task automatic push_rd(input logic [7:0] id, input logic [31:0] addr,
                           input logic [1:0] resp, input logic last);
        rbeat_t b;
        b.data = (resp == 2'b10) ? 32'h0 : model[int'(addr >> 2)];
        b.resp = resp;
        b.last = last;
        b.id   = id;
        exp_q.push_back(b);
    endtask

    task automatic ar_send(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        bus.ARID_S = id; bus.ARADDR_S = addr; bus.ARLEN_S = len;
        bus.ARSIZE_S = size; bus.ARBURST_S = burst; bus.ARVALID_S = 1'b1;
        #1;
        while (!bus.ARREADY_S && n < 100) begin @(posedge clk); #2; n++; end
        chk("ar_accept", 32'(bus.ARREADY_S), 32'd1);
        @(posedge clk); #1;
        bus.ARVALID_S = 1'b0;
    endtask

    task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        bus.AWID_S = id; bus.AWADDR_S = addr; bus.AWLEN_S = len;
        bus.AWSIZE_S = size; bus.AWBURST_S = burst; bus.AWVALID_S = 1'b1;
        #1;
        while (!bus.AWREADY_S && n < 100) begin @(posedge clk); #2; n++; end
        chk("aw_accept", 32'(bus.AWREADY_S), 32'd1);
        @(posedge clk); #1;
        bus.AWVALID_S = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        bus.WDATA_S = data; bus.WSTRB_S = strb; bus.WLAST_S = last; bus.WVALID_S = 1'b1;
        #1;
        while (!bus.WREADY_S && n < 100) begin @(posedge clk); #2; n++; end
        chk("w_accept", 32'(bus.WREADY_S), 32'd1);
        @(posedge clk); #1;
        bus.WVALID_S = 1'b0;
    endtask

    task automatic b_recv(input logic [1:0] resp, input logic [7:0] id);
        int n = 0;
        bus.BREADY_S = 1'b1;
        #1;
        while (!bus.BVALID_S && n < 100) begin @(posedge clk); #2; n++; end
        chk("b_valid", 32'(bus.BVALID_S), 32'd1);
        chk("b_resp",  32'(bus.BRESP_S), 32'(resp));
        chk("b_id",    32'(bus.BID_S), 32'(id));
        @(posedge clk); #1;
        bus.BREADY_S = 1'b0;
    endtask

    task automatic write_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                               input logic [2:0] size, input logic [31:0] base, input logic [3:0] strb,
                               input int nbeats, input int lastidx, input bit upd,
                               input logic [1:0] resp);
        aw_send(id, addr, len, size, 2'b01);
        for (int i = 0; i < nbeats; i++) begin
            w_send(base + 32'(i), strb, (i == lastidx));
            if (upd && i <= int'(len)) model[int'(addr >> 2) + i] = base + 32'(i);
        end
        b_recv(resp, id);
    endtask

    task automatic rd_wait();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(posedge clk); n++; end
        chk("rd_drain", 32'(exp_q.size()), 32'd0);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int b0;
        int n;
        bus.ARID_S = '0; bus.ARADDR_S = '0; bus.ARLEN_S = '0; bus.ARSIZE_S = '0;
        bus.ARBURST_S = '0; bus.ARVALID_S = 1'b0; bus.RREADY_S = 1'b0;
        bus.AWID_S = '0; bus.AWADDR_S = '0; bus.AWLEN_S = '0; bus.AWSIZE_S = '0;
        bus.AWBURST_S = '0; bus.AWVALID_S = 1'b0;
        bus.WDATA_S = '0; bus.WSTRB_S = '0; bus.WLAST_S = 1'b0; bus.WVALID_S = 1'b0;
        bus.BREADY_S = 1'b0;

        tbl[0] = '{8'h11, 32'h100, 4'd3, 3'd2, 2'b01, 2'b00, {32'h10C, 32'h108, 32'h104, 32'h100}};
        tbl[1] = '{8'h12, 32'h108, 4'd3, 3'd2, 2'b10, 2'b00, {32'h104, 32'h100, 32'h10C, 32'h108}};
        tbl[2] = '{8'h13, 32'h104, 4'd1, 3'd2, 2'b00, 2'b00, {32'h0, 32'h0, 32'h104, 32'h104}};
        tbl[3] = '{8'h14, 32'h114, 4'd1, 3'd2, 2'b10, 2'b00, {32'h0, 32'h0, 32'h110, 32'h114}};
        tbl[4] = '{8'h15, 32'h11C, 4'd0, 3'd2, 2'b01, 2'b00, {32'h0, 32'h0, 32'h0, 32'h11C}};
        tbl[5] = '{8'h16, 32'h100, 4'd1, 3'd1, 2'b01, 2'b10, {32'h0, 32'h0, 32'h0, 32'h0}};
        tbl[6] = '{8'h17, 32'h100, 4'd0, 3'd2, 2'b11, 2'b10, {32'h0, 32'h0, 32'h0, 32'h0}};
        tbl[7] = '{8'h18, 32'h100, 4'd2, 3'd2, 2'b10, 2'b10, {32'h0, 32'h0, 32'h0, 32'h0}};

        // Reset: everything quiet while held, both address channels ready after
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", 32'(bus.ARREADY_S), 32'd0);
        chk("rst_awready", 32'(bus.AWREADY_S), 32'd0);
        chk("rst_rvalid",  32'(bus.RVALID_S), 32'd0);
        chk("rst_wready",  32'(bus.WREADY_S), 32'd0);
        chk("rst_bvalid",  32'(bus.BVALID_S), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_arready", 32'(bus.ARREADY_S), 32'd1);
        chk("post_rst_awready", 32'(bus.AWREADY_S), 32'd1);
        chk("post_rst_rdata",   bus.RDATA_S, 32'h0);
        chk("post_rst_rlast",   32'(bus.RLAST_S), 32'd0);
        chk("post_rst_bresp",   32'(bus.BRESP_S), 32'd0);
        chk("post_rst_rid",     32'(bus.RID_S), 32'd0);
        @(posedge clk); #1;
        bus.RREADY_S = 1'b1;

        // Simultaneous AR/AW twice: write wins first after reset, then read
        bus.AWID_S = 8'h21; bus.AWADDR_S = 32'h120; bus.AWLEN_S = 4'd0;
        bus.AWSIZE_S = 3'd2; bus.AWBURST_S = 2'b01; bus.AWVALID_S = 1'b1;
        bus.ARID_S = 8'h22; bus.ARADDR_S = 32'h120; bus.ARLEN_S = 4'd0;
        bus.ARSIZE_S = 3'd2; bus.ARBURST_S = 2'b01; bus.ARVALID_S = 1'b1;
        #1;
        chk("arb1_awready", 32'(bus.AWREADY_S), 32'd1);
        chk("arb1_arready", 32'(bus.ARREADY_S), 32'd0);
        @(posedge clk); #1;
        bus.AWVALID_S = 1'b0;
        w_send(32'hCAFE0120, 4'hF, 1'b1);
        model[32'h120 >> 2] = 32'hCAFE0120;
        b_recv(2'b00, 8'h21);
        bus.AWID_S = 8'h23; bus.AWADDR_S = 32'h124; bus.AWVALID_S = 1'b1;
        push_rd(8'h22, 32'h120, 2'b00, 1'b1);
        #1;
        chk("arb2_arready", 32'(bus.ARREADY_S), 32'd1);
        chk("arb2_awready", 32'(bus.AWREADY_S), 32'd0);
        @(posedge clk); #1;
        bus.ARVALID_S = 1'b0;
        rd_wait();
        aw_send(8'h23, 32'h124, 4'd0, 3'd2, 2'b01);
        w_send(32'hBEEF0124, 4'hF, 1'b1);
        model[32'h124 >> 2] = 32'hBEEF0124;
        b_recv(2'b00, 8'h23);

        // Preload via INCR writes
        write_burst(8'h31, 32'h100, 4'd3, 3'd2, 32'd1,  4'hF, 4, 3, 1'b1, 2'b00);
        write_burst(8'h32, 32'h110, 4'd3, 3'd2, 32'hA0, 4'hF, 4, 3, 1'b1, 2'b00);

        // Table-driven read bursts
        for (int t = 0; t < 8; t++) begin
            for (int b = 0; b <= int'(tbl[t].len); b++)
                push_rd(tbl[t].id, tbl[t].ea[b], tbl[t].resp, (b == int'(tbl[t].len)));
            ar_send(tbl[t].id, tbl[t].addr, tbl[t].len, tbl[t].size, tbl[t].burst);
            rd_wait();
        end

        // RREADY stalled 3 cycles mid-burst
        for (int b = 0; b < 4; b++) push_rd(8'h41, 32'h110 + 32'(4*b), 2'b00, (b == 3));
        b0 = beat_cnt;
        ar_send(8'h41, 32'h110, 4'd3, 3'd2, 2'b01);
        n = 0;
        while (beat_cnt < b0 + 2 && n < 50) begin @(posedge clk); n++; end
        #1;
        bus.RREADY_S = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.RREADY_S = 1'b1;
        rd_wait();
        chk("stall_beat_count", 32'(beat_cnt - b0), 32'd4);

        // Partial byte strobes over all-ones
        write_burst(8'h51, 32'h130, 4'd0, 3'd2, 32'hFFFFFFFF, 4'hF,    1, 0, 1'b1, 2'b00);
        write_burst(8'h52, 32'h130, 4'd0, 3'd2, 32'h12345678, 4'b0101, 1, 0, 1'b0, 2'b00);
        model[32'h130 >> 2] = 32'hFF34FF78;
        push_rd(8'h53, 32'h130, 2'b00, 1'b1);
        ar_send(8'h53, 32'h130, 4'd0, 3'd2, 2'b01);
        rd_wait();

        // Bad AWSIZE: SLVERR and memory untouched
        write_burst(8'h54, 32'h100, 4'd0, 3'd1, 32'hDEAD0000, 4'hF, 1, 0, 1'b0, 2'b10);
        push_rd(8'h55, 32'h100, 2'b00, 1'b1);
        ar_send(8'h55, 32'h100, 4'd0, 3'd2, 2'b01);
        rd_wait();

        // Early WLAST, then missing WLAST (extra beat must not be written)
        write_burst(8'h61, 32'h140, 4'd3, 3'd2, 32'h1400, 4'hF, 2, 1, 1'b0, 2'b10);
        write_burst(8'h62, 32'h158, 4'd0, 3'd2, 32'h5858, 4'hF, 1, 0, 1'b1, 2'b00);
        write_burst(8'h63, 32'h150, 4'd1, 3'd2, 32'h1500, 4'hF, 3, 2, 1'b1, 2'b10);
        push_rd(8'h64, 32'h150, 2'b00, 1'b0);
        push_rd(8'h64, 32'h154, 2'b00, 1'b0);
        push_rd(8'h64, 32'h158, 2'b00, 1'b1);
        ar_send(8'h64, 32'h150, 4'd2, 3'd2, 2'b01);
        rd_wait();

        // Reset during beat 2 of a 4-beat write
        write_burst(8'h70, 32'h168, 4'd0, 3'd2, 32'h6868, 4'hF, 1, 0, 1'b1, 2'b00);
        aw_send(8'h71, 32'h160, 4'd3, 3'd2, 2'b01);
        w_send(32'h7100, 4'hF, 1'b0);
        w_send(32'h7101, 4'hF, 1'b0);
        model[32'h160 >> 2] = 32'h7100;
        model[32'h164 >> 2] = 32'h7101;
        bus.WDATA_S = 32'h7102; bus.WSTRB_S = 4'hF; bus.WLAST_S = 1'b0; bus.WVALID_S = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.WVALID_S = 1'b0;
        #1;
        chk("mid_rst_rvalid",  32'(bus.RVALID_S), 32'd0);
        chk("mid_rst_wready",  32'(bus.WREADY_S), 32'd0);
        chk("mid_rst_bvalid",  32'(bus.BVALID_S), 32'd0);
        chk("mid_rst_awready", 32'(bus.AWREADY_S), 32'd1);
        @(posedge clk); #1;
        push_rd(8'h72, 32'h160, 2'b00, 1'b0);
        push_rd(8'h72, 32'h164, 2'b00, 1'b0);
        push_rd(8'h72, 32'h168, 2'b00, 1'b1);
        ar_send(8'h72, 32'h160, 4'd2, 3'd2, 2'b01);
        rd_wait();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
